bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3), one shift per clock.
- Inverse of the existing binary-to-BCD path. Packed BCD digits, for example from keypad or UART-entered decimal values, become a binary value usable by counters and comparators.
- Start/busy/done handshake. Result is held until the next conversion completes.

---
 rtl/bcd_to_bin_seq.sv | 145 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional input-digit validation enabled by defining BCD_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    logic [BCD_W+BIN_W-1:0] cat_sh;
    logic [BCD_W-1:0]       sh_bcd;
    logic [BCD_W-1:0]       corr_bcd;
    logic [BIN_W-1:0]       sh_bin;

    // Shift the joint register right, then pull each digit >= 8 back by 3 (per nibble, no borrow).
    always_comb begin
        cat_sh   = {bcd_sr_q, bin_sr_q} >> 1;
        sh_bcd   = cat_sh[BCD_W+BIN_W-1:BIN_W];
        sh_bin   = cat_sh[BIN_W-1:0];
        corr_bcd = sh_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd8) begin
                corr_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic bcd_bad;

    always_comb begin
        bcd_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bin_d    = bin_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef BCD_CHECK_EN
                    if (bcd_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        bin_d  = '0;
                    end else begin
                        bcd_sr_d = bcd;
                        bin_sr_d = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = SHIFT;
                    end
`else
                    bcd_sr_d = bcd;
                    bin_sr_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
`endif
                end
            end
            SHIFT: begin
                bcd_sr_d = corr_bcd;
                bin_sr_d = sh_bin;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = sh_bin;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bin_q    <= bin_d;
            err_q    <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases plus randomized traffic vs a decimal-arithmetic model.
// Honours BCD_CHECK_EN the same way as the design.
module tb_bcd_to_bin_seq;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;

    logic                clk = 1'b0;
    logic                reset_p = 1'b1;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] bcd = '0;
    logic                busy, done, err;
    logic [BIN_W-1:0]    bin;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .reset_p(reset_p), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    function automatic int dec_value(input logic [4*DIGITS-1:0] v);
        int acc = 0;
        int w   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            acc += int'(v[4*i +: 4]) * w;
            w   *= 10;
        end
        return acc;
    endfunction

    function automatic bit all_valid(input logic [4*DIGITS-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural model: a conversion is just "remaining cycles" plus the decimal value it will produce.
    int m_rem = 0;
    bit m_done = 0, m_err = 0, m_known = 1, m_pend_known = 1;
    int m_bin = 0, m_pend = 0;

    always @(posedge clk) begin
        if (reset_p) begin
            m_rem = 0; m_done = 0; m_err = 0; m_bin = 0; m_known = 1;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1; m_err = 0; m_bin = m_pend; m_known = m_pend_known;
                end
            end else if (start) begin
`ifdef BCD_CHECK_EN
                if (!all_valid(bcd)) begin
                    m_done = 1; m_err = 1; m_bin = 0; m_known = 1;
                end else begin
                    m_rem = BIN_W; m_pend = dec_value(bcd); m_pend_known = 1;
                end
`else
                m_rem = BIN_W; m_pend = dec_value(bcd); m_pend_known = all_valid(bcd);
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_rem > 0));
        check("done", int'(done), int'(m_done));
        check("err", int'(err), int'(m_err));
        if (m_known) check("bin", int'(bin), m_bin);
    end

    task automatic start_conv(input logic [4*DIGITS-1:0] v);
        @(posedge clk); #1;
        start = 1'b1; bcd = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (done) return;
        end
        check("timeout_waiting_done", 0, 1);
    endtask

    int cyc;

    initial begin
        check("model_1234", dec_value(16'h1234), 1234);
        check("model_9999", dec_value(16'h9999), 9999);
        check("model_valid_12A4", int'(all_valid(16'h12A4)), 0);

        repeat (3) @(posedge clk);
        #1 reset_p = 1'b0;
        @(negedge clk);
        check("reset_bin", int'(bin), 0);
        check("reset_busy", int'(busy), 0);

        start_conv(16'h1234);
        wait_done(cyc);
        check("lat_1234", cyc, BIN_W + 1);
        check("bin_1234", int'(bin), 1234);
        check("err_1234", int'(err), 0);

        start_conv(16'h9999);
        wait_done(cyc);
        check("lat_9999", cyc, BIN_W + 1);
        check("bin_9999", int'(bin), 14'h270F);

        start_conv(16'h0000);
        wait_done(cyc);
        check("lat_0000", cyc, BIN_W + 1);
        check("bin_0000", int'(bin), 0);

        // Restart while busy is ignored; then start held across done gives a back-to-back conversion.
        start_conv(16'h0321);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; bcd = 16'h9876;
        @(posedge clk); #1 start = 1'b0; bcd = 16'h0000;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; bcd = 16'h0042;
        wait_done(cyc);
        check("bin_ignored_restart", int'(bin), 321);
        @(posedge clk); #1 start = 1'b0;
        wait_done(cyc);
        check("lat_back_to_back", cyc, BIN_W + 1);
        check("bin_0042", int'(bin), 42);

        // Reset mid-conversion aborts with no done.
        start_conv(16'h5678);
        repeat (6) @(posedge clk);
        #1 reset_p = 1'b1;
        @(posedge clk); #1 reset_p = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_bin", int'(bin), 0);
        repeat (20) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        start_conv(16'h0007);
        wait_done(cyc);
        check("bin_0007", int'(bin), 7);

        start_conv(16'h12A4);
        wait_done(cyc);
`ifdef BCD_CHECK_EN
        check("lat_invalid", cyc, 1);
        check("err_invalid", int'(err), 1);
        check("bin_invalid", int'(bin), 0);
`else
        check("lat_invalid", cyc, BIN_W + 1);
        check("err_invalid", int'(err), 0);
`endif
        start_conv(16'h0100);
        wait_done(cyc);
        check("bin_0100", int'(bin), 100);
        check("err_0100", int'(err), 0);

        // Randomized traffic: random starts (also while busy), mostly valid digits, rare resets.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            for (int d = 0; d < DIGITS; d++)
                bcd[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
            reset_p = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1 start = 1'b0; reset_p = 1'b0;
        repeat (BIN_W + 3) @(posedge clk);
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
